// File: rtl/debug_sender.sv
// rtl/debug_sender.sv - streams PC, register file and data memory words out byte-wise over a UART tx handshake
module debug_sender #(
    parameter int len       = 32,
    parameter int cant_regs = 32,
    parameter int cant_mem  = 16
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic [len-1:0] pc,
    input  logic [len-1:0] data_in,
    input  logic           tx_done,
    output logic           enable_next,
    output logic           send_regs,
    output logic           restart,
    output logic           tx_start,
    output logic [7:0]     tx_data,
    output logic           busy,
    output logic           done
);

    localparam int NBYTES = len / 8;
    localparam int BCW    = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam int MAXW   = (cant_regs > cant_mem) ? cant_regs : cant_mem;
    localparam int WCW    = $clog2(MAXW + 1);

    localparam logic [BCW-1:0] LAST_BYTE = BCW'(NBYTES - 1);
    localparam logic [WCW-1:0] REGS_N    = WCW'(cant_regs);
    localparam logic [WCW-1:0] MEM_N     = WCW'(cant_mem);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_RESTART = 3'd1;
    localparam logic [2:0] S_FETCH   = 3'd2;
    localparam logic [2:0] S_LATCH   = 3'd3;
    localparam logic [2:0] S_SEND    = 3'd4;
    localparam logic [2:0] S_WAIT_TX = 3'd5;
    localparam logic [2:0] S_NEXT    = 3'd6;
    localparam logic [2:0] S_DONE    = 3'd7;

    localparam logic [1:0] PH_PC   = 2'd0;
    localparam logic [1:0] PH_REGS = 2'd1;
    localparam logic [1:0] PH_MEM  = 2'd2;

    logic [2:0]     state_q, state_d;
    logic [1:0]     phase_q, phase_d;
    logic [len-1:0] word_q, word_d;
    logic [BCW-1:0] byte_cnt_q, byte_cnt_d;
    logic [WCW-1:0] word_cnt_q, word_cnt_d;
    logic [WCW-1:0] word_cnt_inc;
    logic           send_regs_q, send_regs_d;
    logic [7:0]     tx_data_q, tx_data_d;

    assign word_cnt_inc = word_cnt_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        word_d      = word_q;
        byte_cnt_d  = byte_cnt_q;
        word_cnt_d  = word_cnt_q;
        send_regs_d = send_regs_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RESTART;
                end
            end
            S_RESTART: begin
                word_d     = pc;
                phase_d    = PH_PC;
                byte_cnt_d = '0;
                state_d    = S_SEND;
            end
            S_FETCH: begin
                state_d = S_LATCH;
            end
            S_LATCH: begin
                word_d     = data_in;
                byte_cnt_d = '0;
                state_d    = S_SEND;
            end
            S_SEND: begin
                state_d = S_WAIT_TX;
            end
            S_WAIT_TX: begin
                // tx_done is only honoured here, so a pulse coincident with tx_start cannot skip a byte
                if (tx_done) begin
                    word_d     = word_q << 8;
                    byte_cnt_d = byte_cnt_q + 1'b1;
                    state_d    = (byte_cnt_q == LAST_BYTE) ? S_NEXT : S_SEND;
                end
            end
            S_NEXT: begin
                case (phase_q)
                    PH_PC: begin
                        phase_d     = PH_REGS;
                        send_regs_d = 1'b1;
                        word_cnt_d  = '0;
                        state_d     = S_FETCH;
                    end
                    PH_REGS: begin
                        word_cnt_d = word_cnt_inc;
                        state_d    = S_FETCH;
                        if (word_cnt_inc == REGS_N) begin
                            if (cant_mem > 0) begin
                                phase_d     = PH_MEM;
                                send_regs_d = 1'b0;
                                word_cnt_d  = '0;
                            end else begin
                                state_d = S_DONE;
                            end
                        end
                    end
                    default: begin
                        word_cnt_d = word_cnt_inc;
                        state_d    = (word_cnt_inc == MEM_N) ? S_DONE : S_FETCH;
                    end
                endcase
            end
            S_DONE: begin
                send_regs_d = 1'b1;
                state_d     = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Byte is loaded on entry to SEND so tx_data is already valid alongside tx_start
    assign tx_data_d = (state_d == S_SEND) ? word_d[len-1 -: 8] : tx_data_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            phase_q     <= PH_PC;
            word_q      <= '0;
            byte_cnt_q  <= '0;
            word_cnt_q  <= '0;
            send_regs_q <= 1'b1;
            tx_data_q   <= 8'd0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            word_q      <= word_d;
            byte_cnt_q  <= byte_cnt_d;
            word_cnt_q  <= word_cnt_d;
            send_regs_q <= send_regs_d;
            tx_data_q   <= tx_data_d;
        end
    end

    assign enable_next = (state_q == S_FETCH);
    assign restart     = (state_q == S_RESTART);
    assign tx_start    = (state_q == S_SEND);
    assign done        = (state_q == S_DONE);
    assign busy        = (state_q != S_IDLE);
    assign send_regs   = send_regs_q;
    assign tx_data     = tx_data_q;

endmodule

// File: tb/tb_debug_sender.sv
// tb/tb_debug_sender.sv - directed checks of debug_sender with collector and UART models
module tb_debug_sender;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] pc;
    int          uart_delay;
    logic        spur_en;
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;

    logic [31:0] din_a = '0, din_b = '0;
    logic        tx_done_a, tx_done_b, tx_done_ua = 1'b0, tx_done_ub = 1'b0;
    logic        enable_next_a, send_regs_a, restart_a, tx_start_a, busy_a, done_a;
    logic        enable_next_b, send_regs_b, restart_b, tx_start_b, busy_b, done_b;
    logic [7:0]  tx_data_a, tx_data_b;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    debug_sender #(.len(32), .cant_regs(32), .cant_mem(16)) dut_a (
        .clk(clk), .reset(reset), .start(start), .pc(pc), .data_in(din_a), .tx_done(tx_done_a),
        .enable_next(enable_next_a), .send_regs(send_regs_a), .restart(restart_a),
        .tx_start(tx_start_a), .tx_data(tx_data_a), .busy(busy_a), .done(done_a));

    debug_sender #(.len(32), .cant_regs(32), .cant_mem(0)) dut_b (
        .clk(clk), .reset(reset), .start(start), .pc(pc), .data_in(din_b), .tx_done(tx_done_b),
        .enable_next(enable_next_b), .send_regs(send_regs_b), .restart(restart_b),
        .tx_start(tx_start_b), .tx_data(tx_data_b), .busy(busy_b), .done(done_b));

    // Spurious pulses land in FETCH and in SEND (coincident with tx_start)
    assign tx_done_a = tx_done_ua | (spur_en & (enable_next_a | tx_start_a));
    assign tx_done_b = tx_done_ub;

    // Collector models: data valid the cycle after the enable_next strobe
    int ridx_a = 0, midx_a = 0, ridx_b = 0, midx_b = 0;
    always @(posedge clk) begin
        if (restart_a) begin
            ridx_a <= 0; midx_a <= 0;
        end else if (enable_next_a) begin
            if (send_regs_a) begin din_a <= 32'h1000_0000 + ridx_a; ridx_a <= ridx_a + 1; end
            else begin din_a <= 32'hDEAD_0000 + midx_a; midx_a <= midx_a + 1; end
        end
        if (restart_b) begin
            ridx_b <= 0; midx_b <= 0;
        end else if (enable_next_b) begin
            if (send_regs_b) begin din_b <= 32'h1000_0000 + ridx_b; ridx_b <= ridx_b + 1; end
            else begin din_b <= 32'hDEAD_0000 + midx_b; midx_b <= midx_b + 1; end
        end
    end

    // UART models: tx_done uart_delay+1 cycles after tx_start
    int ucnt_a = 0, ucnt_b = 0;
    always @(posedge clk) begin
        if (reset) begin
            ucnt_a <= 0; ucnt_b <= 0; tx_done_ua <= 1'b0; tx_done_ub <= 1'b0;
        end else begin
            tx_done_ua <= 1'b0;
            tx_done_ub <= 1'b0;
            if (tx_start_a) ucnt_a <= uart_delay;
            else if (ucnt_a == 1) begin tx_done_ua <= 1'b1; ucnt_a <= 0; end
            else if (ucnt_a > 1) ucnt_a <= ucnt_a - 1;
            if (tx_start_b) ucnt_b <= uart_delay;
            else if (ucnt_b == 1) begin tx_done_ub <= 1'b1; ucnt_b <= 0; end
            else if (ucnt_b > 1) ucnt_b <= ucnt_b - 1;
        end
    end

    logic [7:0] bytes_a[$], bytes_b[$];
    int         tx_cyc_a[$], en_at_tx_a[$];
    logic       en_sr_a[$];
    int en_cnt_a = 0, rst_cnt_a = 0, done_cnt_a = 0, lat_good_a = 0, lat_bad_a = 0, last_en_cyc_a = 0;
    bit en_pend_a = 1'b0;
    int en_cnt_b = 0, en_sr1_b = 0, rst_cnt_b = 0, done_cnt_b = 0;

    always @(negedge clk) begin
        if (enable_next_a) begin
            en_cnt_a <= en_cnt_a + 1;
            en_sr_a.push_back(send_regs_a);
            last_en_cyc_a <= cyc;
            en_pend_a <= 1'b1;
        end
        if (tx_start_a) begin
            bytes_a.push_back(tx_data_a);
            tx_cyc_a.push_back(cyc);
            en_at_tx_a.push_back(en_cnt_a);
            if (en_pend_a) begin
                if (cyc - last_en_cyc_a == 2) lat_good_a <= lat_good_a + 1;
                else lat_bad_a <= lat_bad_a + 1;
                en_pend_a <= 1'b0;
            end
        end
        if (restart_a) rst_cnt_a <= rst_cnt_a + 1;
        if (done_a) done_cnt_a <= done_cnt_a + 1;
        if (enable_next_b) begin
            en_cnt_b <= en_cnt_b + 1;
            if (send_regs_b) en_sr1_b <= en_sr1_b + 1;
        end
        if (tx_start_b) bytes_b.push_back(tx_data_b);
        if (restart_b) rst_cnt_b <= rst_cnt_b + 1;
        if (done_b) done_cnt_b <= done_cnt_b + 1;
    end

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] word_a(int i);
        if (i + 3 < bytes_a.size()) return {bytes_a[i], bytes_a[i+1], bytes_a[i+2], bytes_a[i+3]};
        return 32'hxxxx_xxxx;
    endfunction

    function automatic logic [31:0] word_b(int i);
        if (i + 3 < bytes_b.size()) return {bytes_b[i], bytes_b[i+1], bytes_b[i+2], bytes_b[i+3]};
        return 32'hxxxx_xxxx;
    endfunction

    task automatic wait_done_a(int n, int budget, string tag);
        int k = 0;
        while (done_cnt_a < n && k < budget) begin @(negedge clk); k++; end
        chk(tag, 32'(done_cnt_a >= n), 32'd1);
        @(negedge clk);
    endtask

    task automatic wait_bytes_a(int n, int budget, string tag);
        int k = 0;
        while (bytes_a.size() < n && k < budget) begin @(negedge clk); k++; end
        chk(tag, 32'(bytes_a.size() >= n), 32'd1);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic chk_reset_outputs(string tag);
        chk({tag, "_busy"}, 32'(busy_a), 32'd0);
        chk({tag, "_send_regs"}, 32'(send_regs_a), 32'd1);
        chk({tag, "_tx_data"}, 32'(tx_data_a), 32'd0);
        chk({tag, "_ctrl"}, 32'({enable_next_a, restart_a, tx_start_a, done_a}), 32'd0);
    endtask

    int b2, d2, r2, b3;
    logic [31:0] gap;

    initial begin
        reset = 1'b0; start = 1'b0; pc = '0; uart_delay = 3; spur_en = 1'b0;
        #3 reset = 1'b1;
        #1 chk_reset_outputs("reset_async");
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        chk("idle_no_tx_start", 32'(bytes_a.size()), 32'd0);
        chk("idle_busy", 32'(busy_a), 32'd0);

        // Dump 1: full dump with spurious tx_done and an ignored second start
        pc = 32'h0040_00A4;
        spur_en = 1'b1;
        pulse_start();
        chk("busy_next_cycle", 32'(busy_a), 32'd1);
        chk("restart_pulse", 32'(restart_a), 32'd1);
        @(negedge clk);
        chk("restart_one_cycle", 32'(restart_a), 32'd0);
        chk("first_tx_start", 32'(tx_start_a), 32'd1);
        chk("first_tx_data", 32'(tx_data_a), 32'h00);
        repeat (18) @(negedge clk);
        pulse_start();
        wait_done_a(1, 5000, "dump1_done_timeout");

        chk("dump1_restart_count", 32'(rst_cnt_a), 32'd1);
        chk("dump1_done_count", 32'(done_cnt_a), 32'd1);
        chk("dump1_total_bytes", 32'(bytes_a.size()), 32'd196);
        chk("pc_bytes", word_a(0), 32'h0040_00A4);
        chk("no_enable_in_pc", 32'((en_at_tx_a.size() > 4) ? en_at_tx_a[3] : -1), 32'd0);
        chk("enable_before_reg0", 32'((en_at_tx_a.size() > 4) ? en_at_tx_a[4] : -1), 32'd1);
        chk("enable_count", 32'(en_cnt_a), 32'd48);
        chk("send_regs_last_reg", 32'((en_sr_a.size() == 48) ? en_sr_a[31] : 1'bx), 32'd1);
        chk("send_regs_first_mem", 32'((en_sr_a.size() == 48) ? en_sr_a[32] : 1'bx), 32'd0);
        chk("reg5_bytes", word_a(24), 32'h1000_0005);
        chk("reg31_bytes", word_a(128), 32'h1000_001F);
        chk("mem0_bytes", word_a(132), 32'hDEAD_0000);
        chk("last_bytes", word_a(192), 32'hDEAD_000F);
        chk("latency_good", 32'(lat_good_a), 32'd48);
        chk("latency_bad", 32'(lat_bad_a), 32'd0);
        chk("busy_after_done", 32'(busy_a), 32'd0);
        chk("send_regs_after_done", 32'(send_regs_a), 32'd1);
        chk("nomem_total_bytes", 32'(bytes_b.size()), 32'd132);
        chk("nomem_last_bytes", word_b(128), 32'h1000_001F);
        chk("nomem_enable_count", 32'(en_cnt_b), 32'd32);
        chk("nomem_send_regs_high", 32'(en_sr1_b), 32'd32);
        chk("nomem_done_count", 32'(done_cnt_b), 32'd1);
        chk("nomem_restart_count", 32'(rst_cnt_b), 32'd1);

        // Dump 2: slow UART, then abort by reset after 50 bytes
        spur_en = 1'b0;
        uart_delay = 100;
        b2 = bytes_a.size(); d2 = done_cnt_a; r2 = rst_cnt_a;
        pc = 32'hCAFE_F00D;
        pulse_start();
        wait_bytes_a(b2 + 2, 1000, "slow_tx_timeout");
        gap = (tx_cyc_a.size() >= b2 + 2) ? 32'(tx_cyc_a[b2+1] - tx_cyc_a[b2]) : 32'd0;
        chk("slow_no_reissue", 32'(gap >= 100), 32'd1);
        chk("slow_second_byte", 32'((bytes_a.size() >= b2 + 2) ? bytes_a[b2+1] : 8'hxx), 32'hFE);
        uart_delay = 3;
        wait_bytes_a(b2 + 50, 2000, "abort_wait_timeout");
        @(negedge clk);
        #1 reset = 1'b1;
        #1 chk_reset_outputs("abort_async");
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        chk("abort_no_done", 32'(done_cnt_a), 32'(d2));
        chk("abort_restart_count", 32'(rst_cnt_a), 32'(r2 + 1));

        // Dump 3: collector resynchronised by the new restart pulse
        pc = 32'h1234_5678;
        b3 = bytes_a.size();
        pulse_start();
        wait_done_a(d2 + 1, 5000, "dump3_done_timeout");
        chk("dump3_restart_count", 32'(rst_cnt_a), 32'(r2 + 2));
        chk("dump3_pc_bytes", word_a(b3), 32'h1234_5678);
        chk("dump3_reg0_bytes", word_a(b3 + 4), 32'h1000_0000);
        chk("dump3_total_bytes", 32'(bytes_a.size() - b3), 32'd196);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/debug_sender.md
Name: debug_sender

Overview:
- Downstream consumer of the debug unit's register/memory collector.
- On a start request it:
  - resets the collector's address counters;
  - sends the current PC;
  - walks all registers, then the configured data-memory words;
  - splits each 32-bit word into bytes handed to the UART transmitter.
- Drives the collector's enable_next/send_regs/restart controls and paces itself on the UART tx_done handshake.

Parameters:
- len, 32, word width of PC/collector data (multiple of 8).
- cant_regs, 32, register words to send (≥1).
- cant_mem, 16, data-memory words to send (≥0; 0 skips memory phase).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle request to begin a dump; ignored unless idle.
- pc  input  len  current program counter; captured in RESTART cycle.
- data_in  input  len  collector data output.
- tx_done  input  1  one-cycle pulse from UART tx when a byte has finished.
- enable_next  output  1  collector advance/latch strobe.
- send_regs  output  1  collector source select (1 = registers, 0 = data memory).
- restart  output  1  collector address-counter clear.
- tx_start  output  1  one-cycle byte-send request to UART tx.
- tx_data  output  8  byte to transmit.
- busy  output  1  high from start acceptance until done.
- done  output  1  one-cycle pulse when the last byte's tx_done is seen.

Behaviour:
- Reset (async, any state):
  - state=IDLE;
  - enable_next, restart, tx_start, busy, done = 0;
  - send_regs=1; tx_data=0;
  - word register, byte counter, word counter cleared.
- States: IDLE, RESTART, FETCH, LATCH, SEND, WAIT_TX, NEXT, DONE.
- IDLE:
  - start=1 → RESTART; busy=1 from next cycle.
- RESTART:
  - restart=1 for exactly one cycle; word<=pc; phase=PC; byte_cnt=0.
  - → SEND.
- FETCH:
  - enable_next=1 for exactly one cycle, with send_regs already stable at the phase value (1 for REGS, 0 for MEM).
  - → LATCH.
- LATCH:
  - collector data valid this cycle; word<=data_in; byte_cnt=0.
  - → SEND.
- SEND:
  - tx_start=1 for one cycle; tx_data=word[len-1:len-8] (MSB byte first, registered, held until next SEND).
  - → WAIT_TX.
- WAIT_TX:
  - waits for tx_done, then word<=word<<8 and byte_cnt++.
  - If byte_cnt was len/8-1 → NEXT, else → SEND.
- NEXT (phase/word sequencing):
  - PC done → phase REGS, send_regs=1, word_cnt=0 → FETCH.
  - REGS: word_cnt++. If word_cnt reaches cant_regs:
    - cant_mem>0 → phase MEM, send_regs=0, word_cnt=0, → FETCH;
    - cant_mem=0 → DONE.
    - Otherwise → FETCH.
  - MEM: word_cnt++. Reaching cant_mem → DONE, else → FETCH.
- DONE:
  - done=1 one cycle; busy=0 next cycle; send_regs returns to 1.
  - → IDLE.
- Total bytes per dump = (len/8)·(1+cant_regs+cant_mem); 196 with defaults.
- Latency from an enable_next strobe to first tx_start of that word is 2 cycles.
- Boundaries:
  - start while busy ignored.
  - tx_done outside WAIT_TX ignored (includes a tx_done coincident with tx_start).
  - enable_next never asserted in PC phase.
  - Exactly cant_regs+cant_mem enable_next strobes per dump.
  - Counter widths sized for cant_regs/cant_mem without wrap.
  - Reset mid-dump aborts immediately with no done pulse. Collector is re-synchronised by the restart pulse of the next dump.

Test Plan:
- Reset idle: assert reset mid-cycle → all outputs at reset values asynchronously; busy=0; no tx_start for 20 cycles.
- PC bytes: pc=0x0040_00A4, start pulse, tx_done 3 cycles after each tx_start.
  - Required: restart pulses once; first four tx_data = 0x00,0x40,0x00,0xA4; no enable_next during these.
- Register walk: collector model returns reg i = 0x1000_0000+i.
  - Required: 32 enable_next strobes with send_regs=1; bytes for reg 5 = 0x10,0x00,0x00,0x05; enable_next→tx_start = 2 cycles.
- Memory phase: mem word j = 0xDEAD_0000+j, cant_mem=16.
  - Required: send_regs falls before the first mem strobe; last four bytes 0xDE,0xAD,0x00,0x0F; done pulses once; 196 total tx_start.
- Handshake robustness:
  - second start while busy → ignored;
  - spurious tx_done during FETCH → no byte skipped;
  - tx_done delayed 100 cycles → tx_start not reissued.
- Abort: reset after 50 bytes, then new start → restart pulses again; byte stream restarts at PC MSB; cant_mem=0 build ends after regs with done.
